// File: rtl/ifu_pkg.sv
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared defaults and queue entry type for the instruction fetch unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_ILEN     = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h4;
    localparam int          INST_BYTES   = 4;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_ILEN-1:0] inst;
    } ifu_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
// ============================================================================
// Module   : ifu_fetch_queue
// Brief    : Synchronous FIFO of fetched {pc, inst} entries with flush
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ifu_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  entry_t        i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [AW:0]   o_count,
    output entry_t        o_head
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Guards keep the pointers coherent even if a caller misuses push/pop.
    assign w_push = i_push & ~i_flush & (r_count != c_full_count);
    assign w_pop  = i_pop  & ~i_flush & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ifu_stream.sv
// ============================================================================
// Module   : ifu_stream
// Brief    : Streaming instruction fetch unit with one request in flight,
//            an instruction queue and redirect squashing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_stream
    import ifu_pkg::*;
#(
    parameter int          XLEN     = IFU_XLEN,
    parameter int          ILEN     = IFU_ILEN,
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_snpc
);

    localparam int              CW          = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] c_reset_pc  = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] c_inst_step = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] c_align     = ~XLEN'(INST_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc_inflight;
    logic            r_outstanding;
    logic            r_drop;

    logic [CW-1:0]   w_count;
    entry_t          w_head;
    entry_t          w_push_data;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_level;

    // The in-flight request reserves a queue slot so its response always fits.
    assign w_level     = w_count + CW'(r_outstanding);
    assign w_req_valid = ~redir_valid & (~r_outstanding | rsp_valid)
                       & (w_level < CW'(QDEPTH));
    assign w_req_fire  = w_req_valid & req_ready;
    assign w_rsp_take  = rsp_valid & r_outstanding;
    assign w_push      = ~redir_valid & w_rsp_take & ~r_drop;
    assign w_pop       = out_valid & out_ready;
    assign w_push_data = '{pc: r_pc_inflight, inst: rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= c_reset_pc;
            r_pc_inflight <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (redir_valid) begin
            r_fetch_pc    <= redir_pc & c_align;
            // A request still in flight must have its response squashed later.
            r_outstanding <= r_outstanding & ~rsp_valid;
            r_drop        <= r_outstanding & ~rsp_valid;
        end else begin
            if (w_req_fire) begin
                r_outstanding <= 1'b1;
                r_pc_inflight <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_inst_step;
            end else if (w_rsp_take) begin
                r_outstanding <= 1'b0;
            end
            if (w_rsp_take) begin
                r_drop <= 1'b0;
            end
        end
    end

    ifu_fetch_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redir_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign req_valid = w_req_valid;
    assign req_addr  = r_fetch_pc;
    assign out_valid = (w_count != '0) & ~redir_valid;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign out_snpc  = w_head.pc + c_inst_step;

endmodule

`default_nettype wire

// File: doc/ifu_stream.md
# ifu_stream

Parametrised instruction fetch unit, the successor to the single-cycle fixed-ROM fetch stage. It fetches from a variable-latency instruction memory over a valid/ready request port, buffers returned instructions with their PCs in a small queue, and delivers them to decode through a valid/ready handshake. Redirects (jumps/branches) squash buffered and in-flight fetches.

## Interface
- XLEN, 64, PC/address width
- ILEN, 32, instruction width
- RESET_PC, 64'h4, fetch PC after reset (truncated to XLEN)
- QDEPTH, 4, instruction queue entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- redir_valid  in  1  redirect request (jump taken)
- redir_pc  in  XLEN  redirect target
- req_valid  out  1  memory fetch request
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address
- rsp_valid  in  1  memory returns data (always accepted)
- rsp_data  in  ILEN  returned instruction
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_inst  out  ILEN  instruction
- out_pc  out  XLEN  its PC
- out_snpc  out  XLEN  out_pc + 4

## Operation
- State: fetch_pc, outstanding (1 bit, at most one request in flight), drop (1 bit), pc_inflight, queue of {pc, inst}, count.
- Issue: req_valid = ~redir_valid & (~outstanding | rsp_valid) & (count + outstanding < QDEPTH). req_addr = fetch_pc.
- On req handshake: outstanding <= 1, pc_inflight <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^XLEN, wraps).
- On rsp_valid: outstanding <= 0 unless a new request issues that cycle; if drop, clear drop and discard data; else push {pc_inflight, rsp_data}.
- Output: out_valid = (count != 0) & ~redir_valid; out_inst/out_pc are queue head; out_snpc = out_pc + 4 (wraps). Pop on out_valid & out_ready.
- Redirect (highest priority): fetch_pc <= {redir_pc[XLEN-1:2], 2'b00} (low bits forced to zero); queue cleared, count <= 0; no request issued and no pop that cycle; if a request is outstanding and no rsp_valid arrives that cycle, drop <= 1; a rsp_valid in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins; drop stays set while the old request is outstanding.
- rsp_valid while no request is outstanding is a protocol error; the unit ignores it.

## Timing
- Reset values: fetch_pc = RESET_PC, outstanding = 0, drop = 0, count = 0, out_valid = 0. req_valid = 1 and req_addr = RESET_PC in the first cycle after reset release.
- req_valid/req_addr are stable until req_ready; req_addr changes only after a handshake or a redirect.
- Fetch latency: request accepted at edge N, response at edge N+k (k >= 1), out_valid high from cycle N+k+1 (no bypass).
- Throughput: 1 instruction/cycle with 1-cycle memory and out_ready held high.
- Full: with count + outstanding = QDEPTH, req_valid = 0 until a pop.
- First fetch after a redirect: req_valid in the cycle after redir_valid, at the new PC. Asynchronous reset mid-fetch returns to the reset state; a late response after reset is ignored.

## Structure
- Package ifu_pkg: default XLEN, ILEN, RESET_PC, INST_BYTES = 4, and the queue entry struct {pc, inst}.
- One sub-module, ifu_fetch_queue: synchronous FIFO of QDEPTH entries with push, pop, flush, count, head outputs, and wrap-around pointers.

## Test plan
- Reset, memory with 1-cycle latency, out_ready = 1 -> req_addr sequence 0x4, 0x8, 0xC…, with one out_pc per cycle starting 0x4 and out_snpc = 0x8.
- out_ready = 0, QDEPTH = 4 -> exactly 4 requests issued, then req_valid stays low; releasing out_ready drains 0x4..0x10 in order.
- Memory latency 3, redir_valid with redir_pc = 0x1002 while a request is outstanding -> stale response discarded; next req_addr = 0x1000; first out_pc = 0x1000.
- Redirect in the same cycle as rsp_valid and a queue holding 2 entries -> queue empty next cycle; out_valid low; no stale PC ever emitted.
- req_ready toggling randomly -> req_addr is held stable while req_valid & ~req_ready; PCs are delivered without gaps or duplicates.
- fetch_pc = 2^XLEN - 4 -> next req_addr = 0; out_snpc of that instruction = 0.
